llr_deinterleaver: RTL and testbench

Row–column block deinterleaver for serial soft-decision LLRs. It sits directly upstream of the 8-to-1 LLR packer in the DeFEC chain. It accepts one 5-bit LLR per `ival` beat, framed by sop/eop/eof, and writes each block row-wise into one half of a ping-pong RAM. It then replays the block column-wise as a gap-free serial stream with the same framing signals, ready to be packed 8 at a time.

---
 rtl/defec_pkg.sv | 19 +
 rtl/llr_dpram.sv | 21 ++
 rtl/llr_deinterleaver.sv | 214 +++++++++++++++++++++
 tb/tb_llr_deinterleaver.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defec_pkg.sv
// Shared types for the DeFEC soft-decision chain.
package defec_pkg;

  localparam int LLR_W = 5;

  typedef logic [LLR_W-1:0] llr_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DONE
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_READ
  } rstate_e;

endpackage

// File: rtl/llr_dpram.sv
// Simple dual-port LLR RAM: one write port, registered read, no reset.
module llr_dpram #(
  parameter int W  = 5,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/llr_deinterleaver.sv
// Ping-pong row/column block deinterleaver for serial LLRs.
module llr_deinterleaver #(
  parameter int LLR_W = defec_pkg::LLR_W,
  parameter int ROWS  = 16,
  parameter int COLS  = 64
) (
  input  logic             clk_h,
  input  logic             rst,
  input  logic             ival,
  input  logic             isop,
  input  logic             ieop,
  input  logic             ieof,
  input  logic [LLR_W-1:0] ibit,
  output logic             oval,
  output logic             osop,
  output logic             oeop,
  output logic             oeof,
  output logic [LLR_W-1:0] obit,
  output logic             oerr
);

  import defec_pkg::*;

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int AW = IW + 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] CMAX = CW'(COLS - 1);

  if ((N % 8) != 0) begin : g_n_check
    $error("llr_deinterleaver: ROWS*COLS must be a multiple of 8");
  end

  function automatic logic [IW-1:0] idx(
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    return IW'(r) * IW'(COLS) + IW'(c);
  endfunction

  wstate_e          wst_q, wst_d;
  logic             wbank_q, wbank_d;
  logic [RW-1:0]    wr_q, wr_d, wr_u;
  logic [CW-1:0]    wc_q, wc_d, wc_u;
  logic [1:0]       full_q, full_d;
  logic [1:0]       eof_q, eof_d;
  logic             err_q, err_d;
  logic             we, wlast, busy, acc;
  logic [AW-1:0]    waddr;

  rstate_e          rs_q, rs_d;
  logic             rbank_q, rbank_d;
  logic [RW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    rc_q, rc_d;
  logic             ren, rlast, rel;
  logic [AW-1:0]    raddr;
  logic [LLR_W-1:0] rdata;

  logic             p1_val_q, p1_sop_q, p1_eop_q, p1_eof_q;
  logic             p1_val_d, p1_sop_d, p1_eop_d, p1_eof_d;
  logic             oval_q, osop_q, oeop_q, oeof_q;
  logic             oval_d, osop_d, oeop_d, oeof_d;
  logic [LLR_W-1:0] obit_q, obit_d;

  // A bank stays full until the cycle after its last read address.
  always_comb begin
    rs_d    = rs_q;
    rbank_d = rbank_q;
    rr_d    = rr_q;
    rc_d    = rc_q;
    ren     = (rs_q == R_READ) || full_q[rbank_q];
    rlast   = (rr_q == RMAX) && (rc_q == CMAX);
    rel     = ren && rlast;
    raddr   = {rbank_q, idx(rr_q, rc_q)};
    if (ren) begin
      rs_d = R_READ;
      if (rr_q == RMAX) begin
        rr_d = '0;
        rc_d = (rc_q == CMAX) ? '0 : rc_q + CW'(1);
      end else begin
        rr_d = rr_q + RW'(1);
      end
      if (rlast) begin
        rs_d    = R_IDLE;
        rbank_d = ~rbank_q;
      end
    end
  end

  always_comb begin
    wst_d   = wst_q;
    wbank_d = wbank_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    full_d  = full_q;
    eof_d   = eof_q;
    err_d   = 1'b0;
    if (rel) full_d[rbank_q] = 1'b0;
    busy  = full_q[wbank_q] && !(rel && (rbank_q == wbank_q));
    acc   = ival && ((wst_q == W_FILL) || (isop && !busy));
    wr_u  = isop ? '0 : wr_q;
    wc_u  = isop ? '0 : wc_q;
    wlast = (wr_u == RMAX) && (wc_u == CMAX);
    we    = acc;
    waddr = {wbank_q, idx(wr_u, wc_u)};
    if (wst_q == W_DONE) wst_d = W_IDLE;
    if (ival && isop && !acc) err_d = 1'b1;
    if (acc) begin
      if (isop && (wst_q == W_FILL)) err_d = 1'b1;
      if (ieop != wlast) begin
        err_d = 1'b1;
        wst_d = W_IDLE;
        wr_d  = '0;
        wc_d  = '0;
      end else if (wlast) begin
        wst_d          = W_DONE;
        full_d[wbank_q] = 1'b1;
        eof_d[wbank_q]  = ieof;
        wbank_d        = ~wbank_q;
        wr_d           = '0;
        wc_d           = '0;
      end else begin
        wst_d = W_FILL;
        if (wc_u == CMAX) begin
          wc_d = '0;
          wr_d = wr_u + RW'(1);
        end else begin
          wc_d = wc_u + CW'(1);
          wr_d = wr_u;
        end
      end
    end
  end

  always_comb begin
    p1_val_d = ren;
    p1_sop_d = ren && (rr_q == '0) && (rc_q == '0);
    p1_eop_d = rel;
    p1_eof_d = rel && eof_q[rbank_q];
    oval_d   = p1_val_q;
    osop_d   = p1_sop_q;
    oeop_d   = p1_eop_q;
    oeof_d   = p1_eof_q;
    obit_d   = p1_val_q ? rdata : '0;
  end

  always_ff @(posedge clk_h) begin
    if (rst) begin
      wst_q    <= W_IDLE;
      wbank_q  <= 1'b0;
      wr_q     <= '0;
      wc_q     <= '0;
      full_q   <= '0;
      eof_q    <= '0;
      err_q    <= 1'b0;
      rs_q     <= R_IDLE;
      rbank_q  <= 1'b0;
      rr_q     <= '0;
      rc_q     <= '0;
      p1_val_q <= 1'b0;
      p1_sop_q <= 1'b0;
      p1_eop_q <= 1'b0;
      p1_eof_q <= 1'b0;
      oval_q   <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      oeof_q   <= 1'b0;
      obit_q   <= '0;
    end else begin
      wst_q    <= wst_d;
      wbank_q  <= wbank_d;
      wr_q     <= wr_d;
      wc_q     <= wc_d;
      full_q   <= full_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      rs_q     <= rs_d;
      rbank_q  <= rbank_d;
      rr_q     <= rr_d;
      rc_q     <= rc_d;
      p1_val_q <= p1_val_d;
      p1_sop_q <= p1_sop_d;
      p1_eop_q <= p1_eop_d;
      p1_eof_q <= p1_eof_d;
      oval_q   <= oval_d;
      osop_q   <= osop_d;
      oeop_q   <= oeop_d;
      oeof_q   <= oeof_d;
      obit_q   <= obit_d;
    end
  end

  llr_dpram #(
    .W (LLR_W),
    .AW(AW)
  ) u_ram (
    .clk  (clk_h),
    .we   (we),
    .waddr(waddr),
    .wdata(ibit),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign oval = oval_q;
  assign osop = osop_q;
  assign oeop = oeop_q;
  assign oeof = oeof_q;
  assign obit = obit_q;
  assign oerr = err_q;

endmodule

// File: tb/tb_llr_deinterleaver.sv
// Self-checking bench: small (4x8) and default (16x64) deinterleavers.
module tb_llr_deinterleaver;

  typedef struct packed {
    logic [4:0] v;
    logic       sop;
    logic       eop;
    logic       eof;
  } out_t;

  typedef struct packed {
    int mode;
    int exp_beats;
    int exp_err;
    int contig;
    int chk_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic ival = 1'b0, isop = 1'b0, ieop = 1'b0, ieof = 1'b0;
  logic [4:0] ibit = '0;
  logic ival_s, ival_l;

  logic s_oval, s_osop, s_oeop, s_oeof, s_oerr;
  logic [4:0] s_obit;
  logic l_oval, l_osop, l_oeop, l_oeof, l_oerr;
  logic [4:0] l_obit;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_eop = -1;
  int nbeats [2];
  int first_cyc [2];
  int last_cyc [2];
  int got_err [2];

  out_t exp_q [2][$];
  logic [4:0] blk [2][$];
  bit coll [2];

  assign ival_s = ival & ~sel;
  assign ival_l = ival & sel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  llr_deinterleaver #(.LLR_W(5), .ROWS(4), .COLS(8)) dut_s (
    .clk_h(clk), .rst(rst), .ival(ival_s), .isop(isop), .ieop(ieop),
    .ieof(ieof), .ibit(ibit), .oval(s_oval), .osop(s_osop),
    .oeop(s_oeop), .oeof(s_oeof), .obit(s_obit), .oerr(s_oerr)
  );

  llr_deinterleaver dut_l (
    .clk_h(clk), .rst(rst), .ival(ival_l), .isop(isop), .ieop(ieop),
    .ieof(ieof), .ibit(ibit), .oval(l_oval), .osop(l_osop),
    .oeop(l_oeop), .oeof(l_oeof), .obit(l_obit), .oerr(l_oerr)
  );

  // Reference: collect a block in input order, emit it column-major.
  task automatic mdl(input int d, input bit v, input bit s, input bit e,
                     input bit f, input logic [4:0] b);
    int r, c, n;
    out_t o;
    r = (d != 0) ? 16 : 4;
    c = (d != 0) ? 64 : 8;
    n = r * c;
    if (!v) return;
    if (s) begin
      coll[d] = 1'b1;
      blk[d].delete();
    end else if (!coll[d]) begin
      return;
    end
    blk[d].push_back(b);
    if (e || blk[d].size() == n) begin
      if (e && blk[d].size() == n) begin
        for (int k = 0; k < n; k++) begin
          o.v   = blk[d][(k % r) * c + k / r];
          o.sop = (k == 0);
          o.eop = (k == n - 1);
          o.eof = (k == n - 1) && f;
          exp_q[d].push_back(o);
        end
      end
      coll[d] = 1'b0;
    end
  endtask

  task automatic beat(input bit v, input bit s, input bit e, input bit f,
                      input logic [4:0] b);
    @(posedge clk);
    #1;
    ival = v; isop = s; ieop = e; ieof = f; ibit = b;
    if (v && e && t_eop < 0) t_eop = cyc;
    mdl(sel ? 1 : 0, v, s, e, f, b);
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic send_blk(input int d, input int pat, input bit eof,
                          input bit gaps, input int len, input bit eop);
    int n;
    logic [4:0] v;
    n = (d != 0) ? 1024 : 32;
    for (int i = 0; i < len; i++) begin
      if (gaps) while ($urandom_range(1) == 0) idle();
      case (pat)
        0: v = 5'(i);
        1: v = 5'(n - 1 - i);
        default: v = 5'($urandom);
      endcase
      beat(1'b1, i == 0, eop && (i == len - 1), eof, v);
    end
  endtask

  task automatic drain(input int bound);
    int k;
    int d;
    k = 0;
    d = sel ? 1 : 0;
    while (exp_q[d].size() != 0 && k < bound) begin
      idle();
      k++;
    end
    checks++;
    if (exp_q[d].size() != 0) begin
      errors++;
      $display("FAIL drain_timeout dut%0d: %0d beats still expected, want 0",
               d, exp_q[d].size());
    end
    repeat (6) idle();
  endtask

  always @(negedge clk) begin
    out_t g, e;
    bit ov, oe;
    for (int d = 0; d < 2; d++) begin
      ov = (d != 0) ? l_oval : s_oval;
      oe = (d != 0) ? l_oerr : s_oerr;
      g.v   = (d != 0) ? l_obit : s_obit;
      g.sop = (d != 0) ? l_osop : s_osop;
      g.eop = (d != 0) ? l_oeop : s_oeop;
      g.eof = (d != 0) ? l_oeof : s_oeof;
      if (rst) continue;
      if (oe) got_err[d]++;
      checks++;
      if (ov) begin
        nbeats[d]++;
        if (first_cyc[d] < 0) first_cyc[d] = cyc;
        last_cyc[d] = cyc;
        if (exp_q[d].size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat dut%0d cyc=%0d: got v=%0d sop=%b eop=%b eof=%b, want no oval",
                   d, cyc, g.v, g.sop, g.eop, g.eof);
        end else begin
          e = exp_q[d].pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL beat dut%0d cyc=%0d: got v=%0d sop=%b eop=%b eof=%b, want v=%0d sop=%b eop=%b eof=%b",
                     d, cyc, g.v, g.sop, g.eop, g.eof, e.v, e.sop, e.eop, e.eof);
          end
        end
      end else if (g !== '0) begin
        errors++;
        $display("FAIL idle_zero dut%0d cyc=%0d: got %h, want 0", d, cyc, g);
      end
    end
  end

  vec_t tbl [8];

  initial begin
    int k;
    tbl[0] = '{mode: 0, exp_beats: 32, exp_err: 0, contig: 1, chk_lat: 1};
    tbl[1] = '{mode: 1, exp_beats: 96, exp_err: 0, contig: 1, chk_lat: 1};
    tbl[2] = '{mode: 2, exp_beats: 32, exp_err: 1, contig: 1, chk_lat: 0};
    tbl[3] = '{mode: 3, exp_beats: 32, exp_err: 1, contig: 1, chk_lat: 1};
    tbl[4] = '{mode: 4, exp_beats: 32, exp_err: 0, contig: 1, chk_lat: 1};
    tbl[5] = '{mode: 5, exp_beats: 64, exp_err: 0, contig: 0, chk_lat: 1};
    tbl[6] = '{mode: 6, exp_beats: 32, exp_err: 1, contig: 1, chk_lat: 0};
    tbl[7] = '{mode: 7, exp_beats: 32, exp_err: 0, contig: 1, chk_lat: 1};

    for (int d = 0; d < 2; d++) begin
      nbeats[d] = 0; first_cyc[d] = -1; last_cyc[d] = -1; got_err[d] = 0;
      coll[d] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_oval, s_osop, s_oeop, s_oeof, s_obit, s_oerr} !== '0) begin
      errors++;
      $display("FAIL reset_small: got %b, want 0",
               {s_oval, s_osop, s_oeop, s_oeof, s_obit, s_oerr});
    end
    checks++;
    if ({l_oval, l_osop, l_oeop, l_oeof, l_obit, l_oerr} !== '0) begin
      errors++;
      $display("FAIL reset_large: got %b, want 0",
               {l_oval, l_osop, l_oeop, l_oeof, l_obit, l_oerr});
    end
    rst = 1'b0;
    repeat (2) idle();

    for (int i = 0; i < 8; i++) begin
      sel = 1'b0;
      nbeats[0] = 0; first_cyc[0] = -1; last_cyc[0] = -1; got_err[0] = 0;
      t_eop = -1;
      case (tbl[i].mode)
        0: send_blk(0, 0, 1'b1, 1'b0, 32, 1'b1);
        1: begin
          send_blk(0, 0, 1'b0, 1'b0, 32, 1'b1);
          send_blk(0, 1, 1'b0, 1'b0, 32, 1'b1);
          send_blk(0, 0, 1'b1, 1'b0, 32, 1'b1);
        end
        2: begin
          send_blk(0, 0, 1'b0, 1'b0, 21, 1'b1);
          send_blk(0, 1, 1'b1, 1'b0, 32, 1'b1);
        end
        3: begin
          send_blk(0, 0, 1'b0, 1'b0, 10, 1'b0);
          send_blk(0, 1, 1'b1, 1'b0, 32, 1'b1);
        end
        4: send_blk(0, 0, 1'b1, 1'b1, 32, 1'b1);
        5: begin
          send_blk(0, 2, 1'($urandom_range(1)), 1'b1, 32, 1'b1);
          send_blk(0, 2, 1'($urandom_range(1)), 1'b1, 32, 1'b1);
        end
        6: begin
          send_blk(0, 0, 1'b1, 1'b0, 32, 1'b0);
          send_blk(0, 1, 1'b1, 1'b0, 32, 1'b1);
        end
        default: begin
          repeat (5) beat(1'b1, 1'b0, 1'b0, 1'b0, 5'($urandom));
          send_blk(0, 0, 1'b1, 1'b0, 32, 1'b1);
        end
      endcase
      drain(400);
      checks++;
      if (nbeats[0] != tbl[i].exp_beats) begin
        errors++;
        $display("FAIL beats_case%0d: got %0d, want %0d", i, nbeats[0], tbl[i].exp_beats);
      end
      checks++;
      if (got_err[0] != tbl[i].exp_err) begin
        errors++;
        $display("FAIL oerr_case%0d: got %0d pulses, want %0d", i, got_err[0], tbl[i].exp_err);
      end
      if (tbl[i].contig != 0) begin
        checks++;
        if (last_cyc[0] - first_cyc[0] + 1 != tbl[i].exp_beats) begin
          errors++;
          $display("FAIL contig_case%0d: got span %0d, want %0d",
                   i, last_cyc[0] - first_cyc[0] + 1, tbl[i].exp_beats);
        end
      end
      if (tbl[i].chk_lat != 0) begin
        checks++;
        if (first_cyc[0] != t_eop + 3) begin
          errors++;
          $display("FAIL latency_case%0d: got first oval at %0d, want %0d",
                   i, first_cyc[0], t_eop + 3);
        end
      end
    end

    // Default geometry: reset in the middle of replay, then a fresh block.
    sel = 1'b1;
    nbeats[1] = 0; first_cyc[1] = -1; got_err[1] = 0;
    send_blk(1, 2, 1'b0, 1'b0, 1024, 1'b1);
    k = 0;
    while (nbeats[1] < 500 && k < 3000) begin
      idle();
      k++;
    end
    checks++;
    if (nbeats[1] < 500) begin
      errors++;
      $display("FAIL large_start: got %0d beats, want >= 500", nbeats[1]);
    end
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      blk[d].delete();
      coll[d] = 1'b0;
    end
    idle();
    rst = 1'b0;
    checks++;
    if ({l_oval, l_osop, l_oeop, l_oeof, l_obit} !== '0) begin
      errors++;
      $display("FAIL large_rst_zero: got %b, want 0",
               {l_oval, l_osop, l_oeop, l_oeof, l_obit});
    end
    repeat (20) idle();
    nbeats[1] = 0;
    send_blk(1, 2, 1'b1, 1'b0, 1024, 1'b1);
    drain(3000);
    checks++;
    if (nbeats[1] != 1024) begin
      errors++;
      $display("FAIL large_after_rst: got %0d beats, want 1024", nbeats[1]);
    end
    checks++;
    if (got_err[1] != 0) begin
      errors++;
      $display("FAIL large_oerr: got %0d pulses, want 0", got_err[1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
